// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Latency-aware hazard unit for the decode stage of the pipelined MIPS core.
// Each architectural register carries a countdown of the stall cycles an
// immediate dependent would still need. A separate countdown tracks the
// single non-pipelined multi-cycle unit (mul/div) for structural hazards.
// The module also keeps a saturating count of the cycles decode was held.

module hazard_scoreboard #(
    parameter int REG_COUNT = 32,
    parameter int REG_AW    = 5,
    parameter int LAT_W     = 4,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issueValidD,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              useRsD,
    input  logic              useRtD,
    input  logic [REG_AW-1:0] writeRegD,
    input  logic              regWriteD,
    input  logic [LAT_W-1:0]  latD,
    input  logic              multiD,
    input  logic              jumpD,
    input  logic              pcSrcD,
    output logic              stallF,
    output logic              stallD,
    output logic              flushE,
    output logic              flushD,
    output logic              mcBusy,
    output logic [PERF_W-1:0] stallCount
);

    // Entry 0 exists only to keep indexing simple; it is never loaded.
    logic [LAT_W-1:0] cnt [REG_COUNT];
    logic [LAT_W-1:0] mc_cnt;

    logic [LAT_W-1:0] rs_cnt;
    logic [LAT_W-1:0] rt_cnt;
    logic [LAT_W-1:0] wr_cnt;

    logic raw_haz;
    logic waw_haz;
    logic str_haz;
    logic stall;
    logic issue;
    logic wr_load;

    // Look up the pending counts of the decode-stage registers; index 0 reads as idle.
    always_comb begin
        rs_cnt = '0;
        rt_cnt = '0;
        wr_cnt = '0;
        for (int r = 1; r < REG_COUNT; r++) begin
            if (rsD == REG_AW'(r)) rs_cnt = cnt[r];
            if (rtD == REG_AW'(r)) rt_cnt = cnt[r];
            if (writeRegD == REG_AW'(r)) wr_cnt = cnt[r];
        end
    end

    // Classify hazards and derive the pipeline control signals.
    always_comb begin
        raw_haz = issueValidD &
                  ((useRsD & (rsD != '0) & (rs_cnt != '0)) |
                   (useRtD & (rtD != '0) & (rt_cnt != '0)));
        // A younger write may not finish ahead of an older one to the same register.
        waw_haz = issueValidD & regWriteD & (writeRegD != '0) & (wr_cnt > latD);
        str_haz = issueValidD & multiD & (mc_cnt != '0);
        stall   = raw_haz | waw_haz | str_haz;
        issue   = issueValidD & ~stall;
        wr_load = issue & regWriteD & (writeRegD != '0) & (latD != '0);
        stallF  = stall;
        stallD  = stall;
        flushE  = stall;
        // A redirect resolved in decode is only honoured once the instruction actually leaves decode.
        flushD  = (jumpD | pcSrcD) & ~stall;
        mcBusy  = (mc_cnt != '0);
    end

    // Per-register countdowns: a new producer's latency overrides the decrement.
    always_ff @(posedge clk) begin
        for (int r = 0; r < REG_COUNT; r++) begin
            if (rst) begin
                cnt[r] <= '0;
            end else if (wr_load && (writeRegD == REG_AW'(r))) begin
                cnt[r] <= latD;
            end else if (cnt[r] != '0) begin
                cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    // Multi-cycle unit occupancy countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc_cnt <= '0;
        end else if (issue && multiD) begin
            mc_cnt <= latD;
        end else if (mc_cnt != '0) begin
            mc_cnt <= mc_cnt - 1'b1;
        end
    end

    // Saturating count of cycles in which decode was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount <= '0;
        end else if (stall && (stallCount != '1)) begin
            stallCount <= stallCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed scenarios for the hazard scoreboard. A reference model tracks,
// for each register, the absolute cycle at which its value becomes usable
// by an immediate dependent, and the cycle at which the multi-cycle unit
// frees up; the expected controls are derived from those times.

module tb_hazard_scoreboard;

    localparam int REG_COUNT = 32;
    localparam int REG_AW    = 5;
    localparam int LAT_W     = 4;
    localparam int PERF_W    = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              issueValidD;
    logic [REG_AW-1:0] rsD;
    logic [REG_AW-1:0] rtD;
    logic              useRsD;
    logic              useRtD;
    logic [REG_AW-1:0] writeRegD;
    logic              regWriteD;
    logic [LAT_W-1:0]  latD;
    logic              multiD;
    logic              jumpD;
    logic              pcSrcD;
    logic              stallF;
    logic              stallD;
    logic              flushE;
    logic              flushD;
    logic              mcBusy;
    logic [PERF_W-1:0] stallCount;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    longint            ready [REG_COUNT];
    longint            mc_free;
    longint            cyc;
    logic [PERF_W-1:0] exp_count;

    hazard_scoreboard #(
        .REG_COUNT(REG_COUNT),
        .REG_AW   (REG_AW),
        .LAT_W    (LAT_W),
        .PERF_W   (PERF_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issueValidD(issueValidD),
        .rsD        (rsD),
        .rtD        (rtD),
        .useRsD     (useRsD),
        .useRtD     (useRtD),
        .writeRegD  (writeRegD),
        .regWriteD  (regWriteD),
        .latD       (latD),
        .multiD     (multiD),
        .jumpD      (jumpD),
        .pcSrcD     (pcSrcD),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushE     (flushE),
        .flushD     (flushD),
        .mcBusy     (mcBusy),
        .stallCount (stallCount)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Stall cycles a dependent of register r would still need right now.
    function automatic longint remaining(input int r);
        if (r == 0) return 0;
        return (ready[r] > cyc) ? ready[r] - cyc : 0;
    endfunction

    function automatic bit modelStall();
        bit raw;
        bit waw;
        bit str;
        raw = issueValidD &&
              ((useRsD && remaining(int'(rsD)) != 0) ||
               (useRtD && remaining(int'(rtD)) != 0));
        waw = issueValidD && regWriteD && (writeRegD != 0) &&
              (remaining(int'(writeRegD)) > longint'(latD));
        str = issueValidD && multiD && (mc_free > cyc);
        return raw || waw || str;
    endfunction

    initial begin
        for (int r = 0; r < REG_COUNT; r++) ready[r] = 0;
        mc_free   = 0;
        cyc       = 0;
        exp_count = '0;
    end

    // Reference model advance at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++) ready[r] <= 0;
            mc_free   <= 0;
            exp_count <= '0;
        end else begin
            if (modelStall()) begin
                if (exp_count != {PERF_W{1'b1}}) exp_count <= exp_count + 1'b1;
            end else if (issueValidD) begin
                if (regWriteD && writeRegD != 0 && latD != 0)
                    ready[writeRegD] <= cyc + 1 + longint'(latD);
                if (multiD)
                    mc_free <= cyc + 1 + longint'(latD);
            end
        end
        cyc <= cyc + 1;
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        if (armed) begin
            bit s;
            s = modelStall();
            checkOutput("stallD", stallD, s);
            checkOutput("stallF", stallF, s);
            checkOutput("flushE", flushE, s);
            checkOutput("flushD", flushD, (jumpD || pcSrcD) && !s);
            checkOutput("mcBusy", mcBusy, mc_free > cyc);
            checkOutput("stallCount", stallCount, exp_count);
        end
    end

    task automatic applyStimulus(input bit v, input int rs, input int rt, input bit urs,
                                 input bit urt, input int wr, input bit rw, input int lat,
                                 input bit mul, input bit jmp, input bit br);
        issueValidD = v;
        rsD         = rs[REG_AW-1:0];
        rtD         = rt[REG_AW-1:0];
        useRsD      = urs;
        useRtD      = urt;
        writeRegD   = wr[REG_AW-1:0];
        regWriteD   = rw;
        latD        = lat[LAT_W-1:0];
        multiD      = mul;
        jumpD       = jmp;
        pcSrcD      = br;
    endtask

    task automatic idle(input int n);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the current instruction in decode until it issues, counting stall cycles.
    task automatic issueWait(input string name, input int exp_stalls);
        int stalls = 0;
        bit done   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stallD) begin
                done = 1'b1;
            end else begin
                stalls++;
                checkOutput({name, " flushE while held"}, flushE, 1);
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: never issued, still stalled after 40 cycles", name);
        end
        checkOutput({name, " stall cycles"}, stalls, exp_stalls);
    endtask

    // Directed scenarios.
    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        armed = 1'b1;

        @(negedge clk);
        checkOutput("reset stallD", stallD, 0);
        checkOutput("reset flushD", flushD, 0);
        checkOutput("reset mcBusy", mcBusy, 0);
        checkOutput("reset stallCount", stallCount, 0);
        @(posedge clk);
        #1;

        // Load-use: one bubble.
        applyStimulus(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
        issueWait("lw $8", 0);
        applyStimulus(1, 8, 3, 1, 1, 11, 1, 0, 0, 0, 0);
        issueWait("add after lw", 1);
        checkOutput("stallCount after load-use", stallCount, 1);

        // Back-to-back muls contend for the unit, then a reader waits for the second result.
        applyStimulus(1, 1, 2, 1, 1, 9, 1, 3, 1, 0, 0);
        issueWait("mul $9", 0);
        applyStimulus(1, 1, 2, 1, 1, 13, 1, 3, 1, 0, 0);
        checkOutput("mcBusy behind mul", mcBusy, 1);
        issueWait("mul $13 behind mul", 3);
        applyStimulus(1, 13, 9, 1, 1, 14, 1, 0, 0, 0, 0);
        issueWait("add reads $13", 3);
        checkOutput("stallCount after mul chain", stallCount, 7);

        // WAW: the load may not complete before the older mul writing the same register.
        idle(2);
        applyStimulus(1, 1, 2, 1, 1, 10, 1, 4, 1, 0, 0);
        issueWait("mul $10", 0);
        applyStimulus(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0);
        issueWait("lw $10 WAW", 3);
        applyStimulus(1, 10, 0, 1, 0, 15, 1, 0, 0, 0, 0);
        issueWait("add reads $10", 1);
        checkOutput("stallCount after WAW", stallCount, 11);

        // Register 0 is never tracked.
        idle(5);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        issueWait("lw $0", 0);
        applyStimulus(1, 0, 0, 1, 1, 16, 1, 0, 0, 0, 0);
        issueWait("add reads $0", 0);
        checkOutput("stallCount after $0", stallCount, 11);

        // Redirect held back while the jump itself is stalled.
        applyStimulus(1, 0, 0, 0, 0, 8, 1, 2, 0, 0, 0);
        issueWait("lw $8 lat2", 0);
        applyStimulus(1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("jump stall1 flushD", flushD, 0);
        checkOutput("jump stall1 stallD", stallD, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("jump stall2 flushD", flushD, 0);
        checkOutput("jump stall2 stallD", stallD, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("jump issue flushD", flushD, 1);
        checkOutput("jump issue stallD", stallD, 0);
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("after jump flushD", flushD, 0);
        @(posedge clk);
        #1;

        // Reset while a mul result is still pending.
        applyStimulus(1, 1, 2, 1, 1, 9, 1, 3, 1, 0, 0);
        issueWait("mul $9 before reset", 0);
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mcBusy before reset edge", mcBusy, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mcBusy after reset", mcBusy, 0);
        checkOutput("stallCount after reset", stallCount, 0);
        applyStimulus(1, 9, 0, 1, 0, 17, 1, 0, 0, 0, 0);
        issueWait("reader of $9 after reset", 0);
        checkOutput("stallCount after reset reader", stallCount, 0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog in case the scenarios stop advancing.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
